// File: rtl/pci_pkg.sv
// Shared definitions for the PCI target address path: bus command codes,
// burst mode codes and the address-phase decoder state encoding.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_RD  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR  = 4'b0111;
    localparam logic [3:0] CMD_RD_MUL  = 4'b1100;
    localparam logic [3:0] CMD_RD_LINE = 4'b1110;
    localparam logic [3:0] CMD_MWI     = 4'b1111;

    localparam logic [1:0] MODE_LINEAR = 2'b00;
    localparam logic [1:0] MODE_WRAP   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACTIVE,
        ST_MISS,
        ST_TURN
    } state_t;

endpackage

// File: rtl/pci_cmd_filter.sv
// Combinational bus-command filter: flags the memory commands this target
// accepts. Shared with the address generator.
module pci_cmd_filter
    import pci_pkg::*;
(
    input  logic [3:0] cmd,
    output logic       supported
);

    // Membership test against the accepted memory command set.
    always_comb begin
        supported = 1'b0;
        case (cmd)
            CMD_MEM_RD, CMD_MEM_WR, CMD_RD_MUL, CMD_RD_LINE, CMD_MWI:
                supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

endmodule

// File: rtl/pci_addr_phase_decoder.sv
// PCI target address-phase decoder: detects the FRAME# falling edge, latches
// the command and address, decides hit/claim and hands the burst start to the
// address generator with a one-cycle en pulse.
// Optional macro PCI_CFG_BAR_EN adds a run-time loadable base register.
module pci_addr_phase_decoder
    import pci_pkg::*;
#(
    parameter int unsigned          AD_W      = 32,
    parameter int unsigned          LA_W      = 4,
    parameter logic [AD_W-1:0]      BASE_ADDR = 32'h0000_1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_n,
    input  logic            irdy_n,
    input  logic [AD_W-1:0] ad,
    input  logic [3:0]      cbe_n,
    input  logic            done,
    output logic [3:0]      cmd,
    output logic [LA_W-1:0] local_address,
    output logic [1:0]      mode,
    output logic            en,
    output logic            devsel_n,
    output logic            cmd_err,
    output logic            busy
`ifdef PCI_CFG_BAR_EN
    ,
    input  logic            cfg_we,
    input  logic [AD_W-1:0] cfg_base
`endif
);

    localparam int unsigned HI_W = AD_W - LA_W - 2;

    state_t          state, next_state;
    logic            frame_q;
    logic            hit_q;
    logic            supported;
    logic            addr_phase;
    logic            bus_idle;
    logic            hit_now;
    logic            latch;
    logic            next_en;
    logic            next_devsel_n;
    logic            next_cmd_err;
    logic [HI_W-1:0] base_hi;

`ifdef PCI_CFG_BAR_EN
    // Base register; a write during DECODE lands after the hit was already
    // captured at the address phase, so it only affects later transactions.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_hi <= BASE_ADDR[AD_W-1:LA_W+2];
        end else if (cfg_we) begin
            base_hi <= cfg_base[AD_W-1:LA_W+2];
        end
    end
`else
    // Fixed base taken from the parameter.
    always_comb begin
        base_hi = BASE_ADDR[AD_W-1:LA_W+2];
    end
`endif

    // Address-phase and bus-idle detection plus the raw hit compare.
    always_comb begin
        addr_phase = frame_q && !frame_n;
        bus_idle   = frame_n && irdy_n;
        hit_now    = (ad[AD_W-1:LA_W+2] == base_hi);
        busy       = (state != ST_IDLE);
    end

    pci_cmd_filter u_cmd_filter (
        .cmd       (cmd),
        .supported (supported)
    );

    // State, registered outputs and address-phase latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            frame_q       <= 1'b1;
            en            <= 1'b0;
            devsel_n      <= 1'b1;
            cmd_err       <= 1'b0;
            cmd           <= '0;
            local_address <= '0;
            mode          <= '0;
            hit_q         <= 1'b0;
        end else begin
            state    <= next_state;
            frame_q  <= frame_n;
            en       <= next_en;
            devsel_n <= next_devsel_n;
            cmd_err  <= next_cmd_err;
            if (latch) begin
                cmd           <= cbe_n;
                local_address <= ad[LA_W+1:2];
                mode          <= ad[1:0];
                hit_q         <= hit_now;
            end
        end
    end

    // Next-state and next-output decode; outputs idle unless a state drives them.
    always_comb begin
        next_state    = state;
        next_en       = 1'b0;
        next_devsel_n = 1'b1;
        next_cmd_err  = 1'b0;
        latch         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (addr_phase) begin
                    latch      = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (hit_q && supported) begin
                    next_en       = 1'b1;
                    next_devsel_n = 1'b0;
                    next_state    = ST_ACTIVE;
                end else if (hit_q) begin
                    next_cmd_err = 1'b1;
                    next_state   = ST_MISS;
                end else begin
                    next_state = ST_MISS;
                end
            end
            ST_ACTIVE: begin
                if (done || bus_idle) begin
                    next_state = ST_TURN;
                end else begin
                    next_devsel_n = 1'b0;
                end
            end
            ST_MISS: begin
                if (bus_idle) begin
                    next_state = ST_IDLE;
                end
            end
            ST_TURN: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pci_addr_phase_decoder.sv
// Scoreboard bench for pci_addr_phase_decoder: the driver predicts each en /
// cmd_err pulse (fields and cycle) into a queue, a monitor pops on every pulse.
module tb_pci_addr_phase_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_n;
    logic        irdy_n;
    logic [31:0] ad;
    logic [3:0]  cbe_n;
    logic        done;
    logic [3:0]  cmd;
    logic [3:0]  local_address;
    logic [1:0]  mode;
    logic        en;
    logic        devsel_n;
    logic        cmd_err;
    logic        busy;
`ifdef PCI_CFG_BAR_EN
    logic        cfg_we;
    logic [31:0] cfg_base;
`endif

    pci_addr_phase_decoder #(
        .AD_W      (32),
        .LA_W      (4),
        .BASE_ADDR (32'h0000_1000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_n       (frame_n),
        .irdy_n        (irdy_n),
        .ad            (ad),
        .cbe_n         (cbe_n),
        .done          (done),
        .cmd           (cmd),
        .local_address (local_address),
        .mode          (mode),
        .en            (en),
        .devsel_n      (devsel_n),
        .cmd_err       (cmd_err),
        .busy          (busy)
`ifdef PCI_CFG_BAR_EN
        ,
        .cfg_we        (cfg_we),
        .cfg_base      (cfg_base)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [3:0] cmd;
        logic [3:0] la;
        logic [1:0] mode;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] base_m = 32'h0000_1000;
    logic [3:0]  lat_cmd = '0;
    logic [3:0]  lat_la  = '0;
    logic [1:0]  lat_mode = '0;
    logic [3:0]  sup_list [5] = '{4'b0110, 4'b0111, 4'b1100, 4'b1110, 4'b1111};

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit is_supported(input logic [3:0] c);
        foreach (sup_list[i]) if (sup_list[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every en / cmd_err pulse must match the oldest prediction.
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (!rst && (en || cmd_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {en, cmd_err}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {en, cmd_err}, e.is_err ? 2'b01 : 2'b10);
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_cmd", cmd, e.cmd);
                if (!e.is_err) begin
                    check("pulse_la", local_address, e.la);
                    check("pulse_mode", mode, e.mode);
                    check("pulse_devsel", devsel_n, 1'b0);
                end
            end
            if (en) check("en_no_repeat", prev_en, 1'b0);
        end
        prev_en = en;
    end

    task automatic check_latched(input string tag);
        check({tag, "_cmd"}, cmd, lat_cmd);
        check({tag, "_la"}, local_address, lat_la);
        check({tag, "_mode"}, mode, lat_mode);
    endtask

    // exit_kind: 0 done, 1 master release, 2 both in the same cycle.
    task automatic txn(input logic [31:0] a, input logic [3:0] c, input int hold,
                       input int exit_kind, input bit collide);
        bit h;
        bit s;
        exp_t e;
        h = ((a >> 6) == (base_m >> 6));
        s = is_supported(c);
        @(negedge clk);
        frame_n = 1'b0; irdy_n = 1'b1; ad = a; cbe_n = c;
        if (h) begin
            e.is_err = !s; e.cmd = c; e.la = a[5:2]; e.mode = a[1:0]; e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
        lat_cmd = c; lat_la = a[5:2]; lat_mode = a[1:0];
        @(negedge clk);
        ad = $urandom; cbe_n = 4'($urandom); irdy_n = 1'b0;
        @(negedge clk);
        if (h && s) begin
            check("claim_devsel", devsel_n, 1'b0);
            if (collide) begin
                frame_n = 1'b1;
                @(negedge clk);
                frame_n = 1'b0; ad = $urandom; cbe_n = 4'($urandom);
                @(negedge clk);
                check_latched("collide");
                check("collide_devsel", devsel_n, 1'b0);
            end
            repeat (hold) @(negedge clk);
            if (exit_kind != 1) done = 1'b1;
            if (exit_kind != 0) begin frame_n = 1'b1; irdy_n = 1'b1; end
            @(negedge clk);
            check("turn_devsel", devsel_n, 1'b1);
            check("turn_busy", busy, 1'b1);
            done = 1'b0; frame_n = 1'b1; irdy_n = 1'b1;
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
        end else begin
            check("noclaim_devsel", devsel_n, 1'b1);
            check("miss_busy", busy, 1'b1);
            repeat (hold) @(negedge clk);
            check("miss_hold_busy", busy, 1'b1);
            frame_n = 1'b1; irdy_n = 1'b1;
            @(negedge clk);
            check("miss_idle_busy", busy, 1'b0);
            check("miss_idle_devsel", devsel_n, 1'b1);
        end
        check_latched("hold");
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd"}, cmd, 4'h0);
        check({tag, "_la"}, local_address, 4'h0);
        check({tag, "_mode"}, mode, 2'b00);
        check({tag, "_en"}, en, 1'b0);
        check({tag, "_devsel"}, devsel_n, 1'b1);
        check({tag, "_cmd_err"}, cmd_err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  c;
        rst = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; ad = '0; cbe_n = '0; done = 1'b0;
`ifdef PCI_CFG_BAR_EN
        cfg_we = 1'b0; cfg_base = '0;
`endif
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        txn(32'h0000_1005, 4'b1110, 2, 0, 1'b0);
        txn(32'h0000_100E, 4'b1100, 1, 1, 1'b0);
        txn(32'h0000_2000, 4'b0110, 3, 1, 1'b0);
        txn(32'h0000_1000, 4'b0010, 2, 1, 1'b0);
        txn(32'h0000_1024, 4'b0111, 1, 2, 1'b1);
        txn(32'h0000_103F, 4'b1111, 0, 0, 1'b0);

        // Reset in the middle of ACTIVE: claim drops with no TURN cycle.
        begin
            exp_t e;
            @(negedge clk);
            frame_n = 1'b0; ad = 32'h0000_1008; cbe_n = 4'b0110;
            e.is_err = 1'b0; e.cmd = 4'b0110; e.la = 4'h2; e.mode = 2'b00; e.cyc = cyc + 2;
            exp_q.push_back(e);
            @(negedge clk); irdy_n = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("pre_reset_devsel", devsel_n, 1'b0);
            rst = 1'b1;
            @(negedge clk);
            check_reset_values("midreset");
            @(negedge clk);
            rst = 1'b0; frame_n = 1'b1; irdy_n = 1'b1;
            lat_cmd = '0; lat_la = '0; lat_mode = '0;
            @(negedge clk);
            check_reset_values("postreset");
        end

`ifdef PCI_CFG_BAR_EN
        @(negedge clk);
        cfg_we = 1'b1; cfg_base = 32'h0000_2000;
        @(negedge clk);
        cfg_we = 1'b0; base_m = 32'h0000_2000;
        txn(32'h0000_2004, 4'b0111, 1, 0, 1'b0);
        txn(32'h0000_1004, 4'b0111, 1, 0, 1'b0);
`endif

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) a = {base_m[31:6], 6'($urandom)};
            else                           a = $urandom;
            if ($urandom_range(0, 2) != 0) c = sup_list[$urandom_range(0, 4)];
            else                           c = 4'($urandom);
            txn(a, c, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pci_addr_phase_decoder.md
Name: pci_addr_phase_decoder

Overview:
- Upstream stage of the PCI target's address generator.
- Samples the PCI address phase (FRAME# falling edge) and latches AD and C/BE#.
- Performs base-address match and command filtering.
- On a hit, claims the transaction (DEVSEL#) and hands cmd, local_address and mode to the address generator with a one-cycle en pulse. It then holds the claim until the generator reports done or the master releases the bus.

Parameters:
- AD_W, 32, AD bus width.
- LA_W, 4, local (dword) address width fed to the address generator.
- BASE_ADDR, 32'h0000_1000, target base address; bits [AD_W-1:LA_W+2] are compared.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- frame_n  in  1  PCI FRAME#, active-low.
- irdy_n  in  1  PCI IRDY#, active-low.
- ad  in  AD_W  PCI AD bus; sampled only in the address phase.
- cbe_n  in  4  PCI C/BE#; carries the bus command in the address phase.
- done  in  1  address generator burst-complete.
- cmd  out  4  latched bus command.
- local_address  out  LA_W  latched ad[LA_W+1:2].
- mode  out  2  latched ad[1:0] (00 linear increment, 10 cacheline wrap, 01/11 passed through).
- en  out  1  one-cycle start pulse to the address generator.
- devsel_n  out  1  DEVSEL#, active-low; claim indication.
- cmd_err  out  1  one-cycle pulse: address hit with unsupported command.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (rst=1 at an edge): cmd=0, local_address=0, mode=0, en=0, devsel_n=1, cmd_err=0, busy=0, frame_q=1, state=IDLE. A reset mid-transaction abandons the transaction immediately, with no turnaround cycle.
- frame_q is a registered copy of frame_n. Address phase is detected when frame_q=1 && frame_n=0.
- Supported commands: 0110 memory read, 0111 memory write, 1100 read multiple, 1110 read line, 1111 write and invalidate.
- hit: ad[AD_W-1:LA_W+2] == BASE_ADDR[AD_W-1:LA_W+2].
- FSM states IDLE, DECODE, ACTIVE, MISS, TURN.
- IDLE: on address-phase detect, latch cbe_n into cmd, ad[LA_W+1:2] into local_address and ad[1:0] into mode, then go to DECODE. Otherwise stay.
- DECODE (one cycle):
  - hit and supported: en=1 and devsel_n=0 on the next edge, then ACTIVE. Fixed latency: en rises 2 edges after the FRAME# falling-edge sample.
  - hit and unsupported: cmd_err=1 for one cycle, then MISS.
  - no hit: go to MISS.
- ACTIVE: en=0 and devsel_n held 0.
  - Exit to TURN when done=1, or when frame_n=1 && irdy_n=1 (master gone).
  - done and master release in the same cycle cause a single exit to TURN.
- TURN (one cycle): devsel_n=1, then IDLE.
- MISS: outputs idle. Wait for frame_n=1 && irdy_n=1, then IDLE.
- A new FRAME# falling edge in any state other than IDLE is ignored; latched values are held.
- Latched cmd, local_address and mode hold their values until the next address phase in IDLE.
- en is never high in two consecutive cycles.

Optional Feature:
- Macro PCI_CFG_BAR_EN.
- Defined: adds ports cfg_we (in, 1) and cfg_base (in, AD_W). A base register, reset to BASE_ADDR, loads cfg_base when cfg_we=1. The hit compare uses this register. A write coinciding with DECODE takes effect for the next transaction only.
- Undefined: no extra ports; the compare uses the BASE_ADDR parameter directly.

Decomposition:
- Shared package pci_pkg:
  - command constants CMD_MEM_RD=4'b0110, CMD_MEM_WR=4'b0111, CMD_RD_MUL=4'b1100, CMD_RD_LINE=4'b1110, CMD_MWI=4'b1111;
  - mode constants MODE_LINEAR=2'b00, MODE_WRAP=2'b10;
  - FSM state encoding.
- Optional combinational sub-module pci_cmd_filter: cmd in, supported flag out. It is also reusable by the address generator.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-ACTIVE -> all outputs at reset values; devsel_n=1 on the next edge with no TURN cycle.
- Read line hit: ad=32'h0000_1005, cbe_n=1110 at the FRAME# fall -> cmd=1110, local_address=4'b0001, mode=01; en pulses exactly once, 2 edges later, with devsel_n=0. done=1 after 4 cycles -> devsel_n=1 in TURN, then IDLE.
- Wrap read multiple: ad=32'h0000_100E, cbe_n=1100 -> local_address=4'b0011, mode=10, en pulse; master raises frame_n and irdy_n before done -> TURN, then IDLE.
- Address miss: ad=32'h0000_2000, cbe_n=0110 -> no en, devsel_n stays 1, busy=1 until the bus is idle.
- Unsupported command: ad=32'h0000_1000, cbe_n=0010 (I/O read) -> cmd_err one-cycle pulse, no en, no devsel.
- Back-to-back and collisions: second FRAME# fall during ACTIVE is ignored (latched outputs unchanged). done and bus release in the same cycle -> single TURN. With PCI_CFG_BAR_EN, write cfg_base=32'h0000_2000, then ad=32'h0000_2004 hits.
